// File: rtl/fpu_pkg.sv
// Shared FPU constants, exception-flag bit positions and the widening-converter state type.
package fpu_pkg;

    localparam int SP_BIAS  = 127;
    localparam int DP_BIAS  = 1023;
    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;
    localparam int DP_EXP_W = 11;
    localparam int DP_MAN_W = 52;

    localparam logic [63:0]         DP_CANON_NAN = 64'h7FF8_0000_0000_0000;
    localparam logic [DP_EXP_W-1:0] DP_INF_EXP   = 11'h7FF;
    localparam logic [DP_EXP_W-1:0] EXP_REBIAS   = 11'(DP_BIAS - SP_BIAS);

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_OUT  = 2'd2
    } cvt_state_e;

    function automatic logic [DP_EXP_W-1:0] sp_to_dp_exp(input logic [SP_EXP_W-1:0] e);
        return {3'd0, e} + EXP_REBIAS;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 operand classifier; exactly one class output is high for any operand.
module fp32_classify (
    input  logic [31:0] op,
    output logic        is_zero,
    output logic        is_sub,
    output logic        is_norm,
    output logic        is_inf,
    output logic        is_snan,
    output logic        is_qnan
);

    logic exp_zero_s;
    logic exp_ones_s;
    logic man_zero_s;

    assign exp_zero_s = (op[30:23] == 8'h00);
    assign exp_ones_s = (op[30:23] == 8'hFF);
    assign man_zero_s = (op[22:0] == 23'd0);

    assign is_zero = exp_zero_s & man_zero_s;
    assign is_sub  = exp_zero_s & ~man_zero_s;
    assign is_norm = ~exp_zero_s & ~exp_ones_s;
    assign is_inf  = exp_ones_s & man_zero_s;
    assign is_snan = exp_ones_s & ~man_zero_s & ~op[22];
    assign is_qnan = exp_ones_s & op[22];

endmodule

// File: rtl/fcvt_s_to_d_seq.sv
// Sequential binary32 -> binary64 widening converter (FCVT.D.S) with valid/ready on both sides.
// Optional NaN-box validation of in_data[63:32] is enabled by defining FCVT_NANBOX_CHECK_EN.
module fcvt_s_to_d_seq
    import fpu_pkg::*;
#(
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          in_data,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [4:0]           out_fflags
);

    cvt_state_e             state_r;
    cvt_state_e             state_nxt_s;
    logic [22:0]            sh_r;
    logic [4:0]             k_r;
    logic                   sign_r;
    logic [63:0]            out_data_r;
    logic [TAG_WIDTH-1:0]   out_tag_r;
    logic [4:0]             out_fflags_r;

    logic                   is_zero_s, is_sub_s, is_norm_s, is_inf_s, is_snan_s, is_qnan_s;
    logic                   box_bad_s;
    logic                   accept_s;
    logic                   go_norm_s;
    logic [23:0]            sh_nxt_s;
    logic [63:0]            res_data_s;
    logic [4:0]             res_flags_s;

    fp32_classify u_classify (
        .op      (in_data[31:0]),
        .is_zero (is_zero_s),
        .is_sub  (is_sub_s),
        .is_norm (is_norm_s),
        .is_inf  (is_inf_s),
        .is_snan (is_snan_s),
        .is_qnan (is_qnan_s)
    );

`ifdef FCVT_NANBOX_CHECK_EN
    assign box_bad_s = (in_data[63:32] != 32'hFFFF_FFFF);
`else
    logic nanbox_unused_s;
    assign nanbox_unused_s = ^in_data[63:32];
    assign box_bad_s       = 1'b0;
`endif

    assign in_ready  = (state_r == ST_IDLE) | ((state_r == ST_OUT) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign go_norm_s = is_sub_s & ~box_bad_s;
    // The shift register holds F without its always-zero top bit; bit 23 of the next value is the hidden 1.
    assign sh_nxt_s  = {sh_r, 1'b0};

    assign out_valid  = (state_r == ST_OUT);
    assign out_data   = out_data_r;
    assign out_tag    = out_tag_r;
    assign out_fflags = out_fflags_r;

    // Single-cycle result for every class except subnormal.
    always_comb begin
        res_data_s  = 64'd0;
        res_flags_s = 5'd0;
        if (box_bad_s) begin
            res_data_s = DP_CANON_NAN;
        end else if (is_snan_s | is_qnan_s) begin
            res_data_s            = DP_CANON_NAN;
            res_flags_s[FFLAG_NV] = is_snan_s;
        end else if (is_inf_s) begin
            res_data_s = {in_data[31], DP_INF_EXP, 52'd0};
        end else if (is_norm_s) begin
            res_data_s = {in_data[31], sp_to_dp_exp(in_data[30:23]), in_data[22:0], 29'd0};
        end else if (is_zero_s) begin
            res_data_s = {in_data[31], 63'd0};
        end else begin
            res_data_s = 64'd0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = go_norm_s ? ST_NORM : ST_OUT;
                else          state_nxt_s = ST_IDLE;
            end
            ST_NORM: begin
                if (sh_nxt_s[23]) state_nxt_s = ST_OUT;
                else              state_nxt_s = ST_NORM;
            end
            ST_OUT: begin
                if (accept_s)       state_nxt_s = go_norm_s ? ST_NORM : ST_OUT;
                else if (out_ready) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Datapath: capture on accept, normalise subnormals one bit per cycle, hold result while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r         <= 23'd0;
            k_r          <= 5'd0;
            sign_r       <= 1'b0;
            out_data_r   <= 64'd0;
            out_tag_r    <= '0;
            out_fflags_r <= 5'd0;
        end else if (accept_s) begin
            out_tag_r <= in_tag;
            if (go_norm_s) begin
                sign_r <= in_data[31];
                sh_r   <= in_data[22:0];
                k_r    <= 5'd0;
            end else begin
                out_data_r   <= res_data_s;
                out_fflags_r <= res_flags_s;
            end
        end else if (state_r == ST_NORM) begin
            sh_r <= sh_nxt_s[22:0];
            k_r  <= k_r + 5'd1;
            // Exponent 897-(k_r+1) after this shift, i.e. 896-k_r.
            if (sh_nxt_s[23]) begin
                out_data_r   <= {sign_r, EXP_REBIAS - {6'd0, k_r}, sh_nxt_s[22:0], 29'd0};
                out_fflags_r <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_s_to_d_seq.sv
// Randomised and directed self-checking bench for fcvt_s_to_d_seq against a value-level reference model.
module tb_fcvt_s_to_d_seq;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic [TW-1:0] out_tag;
    logic [4:0]    out_fflags;

    int total = 0;
    int bad   = 0;

    fcvt_s_to_d_seq #(.TAG_WIDTH(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_fflags (out_fflags)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Value-level model: the binary64 equal to the binary32 value, plus flags and expected latency.
    function automatic void ref_cvt(input logic [63:0] d, output logic [63:0] r,
                                    output logic [4:0] fl, output int lat);
        logic        s;
        int          e;
        logic [22:0] f;
        logic [63:0] m;
        int          p;
        int          k;
        s   = d[31];
        e   = int'(d[30:23]);
        f   = d[22:0];
        fl  = 5'd0;
        lat = 1;
        r   = 64'd0;
`ifdef FCVT_NANBOX_CHECK_EN
        if (d[63:32] != 32'hFFFF_FFFF) begin
            r = 64'h7FF8_0000_0000_0000;
            return;
        end
`endif
        if (e == 255) begin
            if (f == 23'd0) r = {s, 11'h7FF, 52'd0};
            else begin
                r  = 64'h7FF8_0000_0000_0000;
                fl = f[22] ? 5'b00000 : 5'b10000;
            end
        end else if (e == 0 && f == 23'd0) begin
            r = {s, 63'd0};
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < 23; i++) if (f[i]) p = i;
            k   = 23 - p;
            m   = 64'(f) << k;
            r   = {s, 11'(897 - k), m[22:0], 29'd0};
            lat = 1 + k;
        end else begin
            r = {s, 11'(e + 896), f, 29'd0};
        end
    endfunction

    task automatic run_op(input logic [63:0] d, input logic [TW-1:0] tag, input string name);
        logic [63:0] er;
        logic [4:0]  ef;
        int          el;
        int          lat;
        int          hold;
        bit          saw_ready;
        ref_cvt(d, er, ef, el);
        @(negedge clk);
        out_ready = 1'b0;
        in_data   = d;
        in_tag    = tag;
        in_valid  = 1'b1;
        check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat       = 0;
        saw_ready = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) saw_ready = 1'b1;
        end
        check_eq({name, "_latency"}, 64'(lat), 64'(el));
        check_eq({name, "_busy_ready"}, 64'(saw_ready), 64'd0);
        check_eq({name, "_data"}, out_data, er);
        check_eq({name, "_fflags"}, 64'(out_fflags), 64'(ef));
        check_eq({name, "_tag"}, 64'(out_tag), 64'(tag));
        hold = int'($urandom_range(0, 2));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check_eq({name, "_held"}, {out_data[62:0], out_valid}, {er[62:0], 1'b1});
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({name, "_drained"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    function automatic logic [63:0] rand_op();
        logic [22:0] f;
        int          cls;
        logic [31:0] box;
        cls = int'($urandom_range(0, 4));
        f   = 23'($urandom);
        box = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
        case (cls)
            0:       return {box, 1'($urandom), 8'($urandom_range(1, 254)), f};
            1: begin
                f = f >> $urandom_range(0, 22);
                if (f == 23'd0) f = 23'd1;
                return {box, 1'($urandom), 8'd0, f};
            end
            2:       return {box, 1'($urandom), 31'd0};
            3:       return {box, 1'($urandom), 8'hFF, 23'd0};
            default: begin
                if (f == 23'd0) f = 23'd1;
                return {box, 1'($urandom), 8'hFF, f};
            end
        endcase
    endfunction

    logic [63:0] exp_d;
    logic [4:0]  exp_f;
    int          exp_l;
    logic [63:0] ops [4];
    bit          leaked;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_out_fflags", 64'(out_fflags), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed values with hand-derived results.
        run_op({32'hFFFF_FFFF, 32'h3F80_0000}, 5'd1, "one");
        check_eq("one_const", out_data, 64'h3FF0_0000_0000_0000);
        run_op({32'hFFFF_FFFF, 32'hC020_0000}, 5'd2, "m2p5");
        run_op({32'hFFFF_FFFF, 32'h8000_0000}, 5'd3, "negzero");
        run_op({32'hFFFF_FFFF, 32'hFF80_0000}, 5'd4, "neginf");
        run_op({32'hFFFF_FFFF, 32'h7F80_0001}, 5'd5, "snan");
        run_op({32'hFFFF_FFFF, 32'h7FC0_0000}, 5'd6, "qnan");
        run_op({32'hFFFF_FFFF, 32'h0040_0000}, 5'd7, "sub_big");
        run_op({32'hFFFF_FFFF, 32'h0000_0001}, 5'd8, "sub_min");
        run_op({32'h0000_0000, 32'h3F80_0000}, 5'd9, "badbox");

        // Randomised operands.
        for (int i = 0; i < 120; i++) run_op(rand_op(), 5'($urandom), "rand");

        // Streaming: one result per cycle with out_ready held high.
        for (int i = 0; i < 4; i++) ops[i] = {32'hFFFF_FFFF, 1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                ref_cvt(ops[i-1], exp_d, exp_f, exp_l);
                check_eq("stream_valid", 64'(out_valid), 64'd1);
                check_eq("stream_data", out_data, exp_d);
                check_eq("stream_tag", 64'(out_tag), 64'(i - 1));
            end
            if (i < 4) begin
                check_eq("stream_ready", 64'(in_ready), 64'd1);
                in_data  = ops[i];
                in_tag   = 5'(i);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("stream_end", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Backpressure: tag 3 stalls, tag 4 waits at the input.
        @(negedge clk);
        in_data  = {32'hFFFF_FFFF, 32'h3F80_0000};
        in_tag   = 5'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = {32'hFFFF_FFFF, 32'hC020_0000};
        in_tag  = 5'd4;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 64'(out_valid), 64'd1);
            check_eq("bp_data", out_data, 64'h3FF0_0000_0000_0000);
            check_eq("bp_tag", 64'(out_tag), 64'd3);
            check_eq("bp_no_accept", 64'(in_ready), 64'd0);
            if (i < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bp_next_valid", 64'(out_valid), 64'd1);
        check_eq("bp_next_data", out_data, 64'hC004_0000_0000_0000);
        check_eq("bp_next_tag", 64'(out_tag), 64'd4);
        @(negedge clk);
        check_eq("bp_drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Reset in the middle of normalising the smallest subnormal.
        @(negedge clk);
        in_data  = {32'hFFFF_FFFF, 32'h0000_0001};
        in_tag   = 5'd10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("norm_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        leaked = 1'b0;
        out_ready = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        out_ready = 1'b0;
        check_eq("midrst_no_output", 64'(leaked), 64'd0);
        run_op({32'hFFFF_FFFF, 32'h3F80_0000}, 5'd11, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
